// File: rtl/sap_ctrl_pkg.sv
// Shared types and constants for the SAP control sequencer: FSM states,
// opcode encodings and the bus-control word that drives the datapath.
package sap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC1 = 3'd1,
    ST_EXEC2 = 3'd2,
    ST_DONE  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic in_en;
    logic nLa;
    logic Ea;
    logic nLb;
    logic Eb;
    logic Eu;
    logic sub;
    logic out_ld;
  } cw_t;

  // Nothing drives the bus and both register loads (active-low) are off.
  localparam cw_t CW_IDLE = '{in_en: 1'b0, nLa: 1'b1, Ea: 1'b0, nLb: 1'b1,
                              Eb: 1'b0, Eu: 1'b0, sub: 1'b0, out_ld: 1'b0};

  // Opcodes that spend a cycle in EXEC1 driving the datapath.
  function automatic logic is_exec_op(input logic [3:0] op);
    return (op >= OP_LDA) && (op <= OP_OUT);
  endfunction

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational control-word decode from the sequencer state and latched
// opcode; only EXEC1 ever asserts a non-idle word.
module sap_ctrl_decode
  import sap_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] op_i,
  output cw_t        cw_o
);

  always_comb begin
    cw_o = CW_IDLE;
    if (state_i == ST_EXEC1) begin
      case (op_i)
        OP_LDA: begin
          cw_o.in_en = 1'b1;
          cw_o.nLa   = 1'b0;
        end
        OP_LDB: begin
          cw_o.in_en = 1'b1;
          cw_o.nLb   = 1'b0;
        end
        OP_ADD, OP_SUB: begin
          cw_o.Eu  = 1'b1;
          cw_o.nLa = 1'b0;
          cw_o.sub = (op_i == OP_SUB);
        end
        OP_OUT: begin
          cw_o.Ea     = 1'b1;
          cw_o.out_ld = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: accepts one opcode per handshake, steps the T-state
// FSM, drives the datapath control word and captures ALU flags.
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [OP_W-1:0] opcode,
  input  logic            cf_in,
  input  logic            zf_in,
  output logic            in_en,
  output logic            nLa,
  output logic            nLb,
  output logic            Ea,
  output logic            Eb,
  output logic            Eu,
  output logic            sub,
  output logic            out_ld,
  output logic            done,
  output logic            illegal,
  output logic            halted,
  output logic            cf_q,
  output logic            zf_q,
  output state_e          dbg_state_o
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       cf_d, zf_d, cf_r, zf_r;
  cw_t        cw;

  // Handshake: an opcode transfers on a rising edge where op_valid & op_ready
  // are both high; op_ready depends only on state, and the producer must hold
  // op_valid/opcode stable until that edge.
  assign op_ready = (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'h0;
      cf_r    <= 1'b0;
      zf_r    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cf_r    <= cf_d;
      zf_r    <= zf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cf_d    = cf_r;
    zf_d    = zf_r;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d = opcode[3:0];
          if (is_exec_op(opcode[3:0]))   state_d = ST_EXEC1;
          else if (opcode[3:0] == OP_HLT) state_d = ST_HALT;
          else                            state_d = ST_DONE;
        end
      end
      ST_EXEC1: state_d = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? ST_EXEC2 : ST_DONE;
      ST_EXEC2: begin
        // The ALU result settled during EXEC1's A load; its flags are taken now.
        cf_d    = cf_in;
        zf_d    = zf_in;
        state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  sap_ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (op_q),
    .cw_o    (cw)
  );

  assign in_en   = cw.in_en;
  assign nLa     = cw.nLa;
  assign nLb     = cw.nLb;
  assign Ea      = cw.Ea;
  assign Eb      = cw.Eb;
  assign Eu      = cw.Eu;
  assign sub     = cw.sub;
  assign out_ld  = cw.out_ld;

  assign done    = (state_q == ST_DONE);
  assign illegal = done && !((op_q == OP_NOP) || is_exec_op(op_q));
  assign halted  = (state_q == ST_HALT);
  assign cf_q    = cf_r;
  assign zf_q    = zf_r;
  assign dbg_state_o = state_q;

endmodule
